// File: rtl/serial_addsub_unit_if.sv
// Handshake and data bus for serial_addsub_unit.
// Optional port acc exists only when SERIAL_ADDSUB_ACCUM_EN is defined.
`timescale 1ns/1ps
interface serial_addsub_unit_if #(
  parameter int WIDTH = 8
);
`ifdef SERIAL_ADDSUB_ACCUM_EN
  logic             acc;
`endif
  logic             start;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] adata;
  logic [WIDTH-1:0] bdata;
  logic             enable;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] pout;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SERIAL_ADDSUB_ACCUM_EN
    output acc,
`endif
    output start, mode, cin, adata, bdata, enable,
    input  ready, busy, done, pout, cout, ovf
  );

  modport slave (
`ifdef SERIAL_ADDSUB_ACCUM_EN
    input  acc,
`endif
    input  start, mode, cin, adata, bdata, enable,
    output ready, busy, done, pout, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor, LSB first, one full-adder cell plus carry flop.
// Optional accumulate mode (A operand taken from the last result) is enabled
// by defining SERIAL_ADDSUB_ACCUM_EN.
`timescale 1ns/1ps
module serial_addsub_unit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                 clk,
  input logic                 rst,
  serial_addsub_unit_if.slave bus
);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("serial_addsub_unit: WIDTH must be >= 2");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             c;
  logic             c_msb;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] pout_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] a_load;

  // Full-adder cell and A-operand source selection
  always_comb begin
    sum_bit    = a_sr[0] ^ b_sr[0] ^ c;
    carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
`ifdef SERIAL_ADDSUB_ACCUM_EN
    a_load     = bus.acc ? pout_q : bus.adata;
`else
    a_load     = bus.adata;
`endif
  end

  // Control FSM and serial datapath; subtract is folded in at load time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      c     <= 1'b0;
      c_msb <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sr  <= a_load;
            b_sr  <= bus.mode ? ~bus.bdata : bus.bdata;
            c     <= bus.mode ? ~bus.cin : bus.cin;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bus.enable) begin
            c    <= carry_next;
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            r_sr <= {sum_bit, r_sr[WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
              c_msb <= c;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Result registers update only on completion; done is a one-cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout_q <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      if (state == S_DONE) begin
        pout_q <= r_sr;
        cout_q <= c;
        ovf_q  <= c_msb ^ c;
      end
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.busy  = (state == S_SHIFT) || (state == S_DONE);
  assign bus.done  = done_q;
  assign bus.pout  = pout_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit (8-bit main instance, 16-bit regression).
`timescale 1ns/1ps
module tb_serial_addsub_unit;

  localparam int W   = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_addsub_unit_if #(.WIDTH(W))   bus ();
  serial_addsub_unit_if #(.WIDTH(W16)) bus16 ();

  serial_addsub_unit #(.WIDTH(W))   dut   (.clk(clk), .rst(rst), .bus(bus));
  serial_addsub_unit #(.WIDTH(W16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    logic [W-1:0] pout;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  logic [W-1:0] model_acc   = '0;
  logic [W-1:0] mon_pout    = '0;
  logic         mon_cout    = 1'b0;
  logic         mon_ovf     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, unsigned for result/carry, signed for overflow
  function automatic exp_t ref_op(input logic mode, input logic cin,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sb, ci, usum, ssum;
    ua = int'(a);
    ub = int'(b);
    ci = cin ? 1 : 0;
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (!mode) begin
      usum = ua + ub + ci;
      ssum = sa + sb + ci;
    end else begin
      usum = ua + ((1 << W) - 1 - ub) + (1 - ci);
      ssum = sa - sb - ci;
    end
    e.pout = usum[W-1:0];
    e.cout = usum[W];
    e.ovf  = (ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)));
    e.due  = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitor: pop and compare on each done; otherwise outputs must hold
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got done=1 pout=%h, want no done", bus.pout);
        end else begin
          mon_e = sbq.pop_front();
          if (bus.pout !== mon_e.pout || bus.cout !== mon_e.cout ||
              bus.ovf !== mon_e.ovf || cyc != mon_e.due) begin
            miscompares++;
            $display("FAIL result: got pout=%h cout=%b ovf=%b cyc=%0d, want pout=%h cout=%b ovf=%b cyc=%0d",
                     bus.pout, bus.cout, bus.ovf, cyc, mon_e.pout, mon_e.cout, mon_e.ovf, mon_e.due);
          end
          mon_pout = mon_e.pout;
          mon_cout = mon_e.cout;
          mon_ovf  = mon_e.ovf;
        end
      end else begin
        vectors++;
        if (bus.pout !== mon_pout || bus.cout !== mon_cout || bus.ovf !== mon_ovf ||
            bus.ready !== ~bus.busy) begin
          miscompares++;
          $display("FAIL hold: got pout=%h cout=%b ovf=%b ready=%b busy=%b, want pout=%h cout=%b ovf=%b ready=~busy",
                   bus.pout, bus.cout, bus.ovf, bus.ready, bus.busy, mon_pout, mon_cout, mon_ovf);
        end
      end
    end
  end

  // Issue one operation; called just after a falling edge, returns likewise
  task automatic issue(input logic mode, input logic cin, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic acc, input int stall_at,
                       input int stall_len, input bit spurious, input bit expect_it);
    exp_t         e;
    logic [W-1:0] a_eff;
    int           guard;
    guard = 0;
    while (!bus.ready) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout: got ready=0 after %0d cycles, want ready=1", guard);
        return;
      end
    end
    a_eff = a;
`ifdef SERIAL_ADDSUB_ACCUM_EN
    bus.acc = acc;
    if (acc) a_eff = model_acc;
`else
    if (acc) a_eff = a;
`endif
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.cin   = cin;
    bus.adata = a;
    bus.bdata = b;
    e = ref_op(mode, cin, a_eff, b);
    e.due = cyc + W + 2 + stall_len;
    model_acc = e.pout;
    if (expect_it) sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 1'($urandom);
    bus.cin   = 1'($urandom);
    bus.adata = W'($urandom);
    bus.bdata = W'($urandom);
`ifdef SERIAL_ADDSUB_ACCUM_EN
    bus.acc   = 1'($urandom);
`endif
    for (int k = 1; k < stall_at + stall_len; k++) begin
      bus.enable = !(k >= stall_at);
      bus.start  = spurious && (k == stall_at);
      @(negedge clk);
    end
    bus.enable = 1'b1;
    bus.start  = 1'b0;
  endtask

  initial begin
    int guard;
    int s16;
    bus.start = 0; bus.mode = 0; bus.cin = 0; bus.adata = '0; bus.bdata = '0; bus.enable = 1;
    bus16.start = 0; bus16.mode = 0; bus16.cin = 0; bus16.adata = '0; bus16.bdata = '0; bus16.enable = 1;
`ifdef SERIAL_ADDSUB_ACCUM_EN
    bus.acc = 0;
    bus16.acc = 0;
`endif
    #2;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_busy",  32'(bus.busy),  32'd0);
    check("reset_done",  32'(bus.done),  32'd0);
    check("reset_pout",  32'(bus.pout),  32'd0);
    check("reset_cout",  32'(bus.cout),  32'd0);
    check("reset_ovf",   32'(bus.ovf),   32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Directed cases, issued back to back where no stall is requested
    issue(1'b0, 1'b0, 8'h01, 8'h02, 1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 8'h05, 8'h07, 1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 8'h80, 8'h01, 1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 8'h02, 8'h03, 1'b0, 3, 4, 1'b1, 1'b1);

`ifdef SERIAL_ADDSUB_ACCUM_EN
    issue(1'b0, 1'b0, 8'h0A, 8'h00, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) issue(1'b0, 1'b0, 8'h00, 8'h05, 1'b1, 0, 0, 1'b0, 1'b1);
`endif

    // Randomized operations with random stalls and ignored starts
    for (int i = 0; i < 40; i++) begin
      int sl;
      sl = $urandom_range(0, 3);
      issue(1'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
            $urandom_range(1, W), sl, 1'($urandom), 1'b1);
    end

    // Abort 0x55+0x0A during bit 4
    issue(1'b0, 1'b0, 8'h55, 8'h0A, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_done",  32'(bus.done),  32'd0);
    check("abort_pout",  32'(bus.pout),  32'd0);
    check("abort_cout",  32'(bus.cout),  32'd0);
    check("abort_ovf",   32'(bus.ovf),   32'd0);
    sbq.delete();
    model_acc = '0;
    mon_pout  = '0;
    mon_cout  = 1'b0;
    mon_ovf   = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 1'b0, 8'h01, 8'h02, 1'b0, 0, 0, 1'b0, 1'b1);

    // Drain the scoreboard, then watch for any stray done pulse
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending results, want 0", sbq.size());
    end
    repeat (20) @(negedge clk);

    // 16-bit regression: 0xFFFF + 0x0001
    s16 = cyc;
    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.cin = 1'b0;
    bus16.adata = 16'hFFFF; bus16.bdata = 16'h0001;
    @(negedge clk);
    bus16.start = 1'b0;
    guard = 0;
    while (!bus16.done && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("w16_latency", 32'(cyc - s16), 32'(W16 + 2));
    check("w16_pout", 32'(bus16.pout), 32'h0000);
    check("w16_cout", 32'(bus16.cout), 32'd1);
    check("w16_ovf",  32'(bus16.ovf),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
Parametrised bit-serial adder/subtractor, LSB-first, one bit per enabled clock, using one full-adder cell and a carry flip-flop. Operands are loaded in parallel. The result, carry-out and signed overflow are presented in parallel on completion. A start/ready/done handshake lets a controller sequence back-to-back operations. This is the next generation of the team's fixed 8-bit serial adder, adding width, subtract mode, carry-in, stall and status flags.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2 (elaboration error otherwise)
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden

Ports:
clk     input   1      rising-edge clock
rst     input   1      asynchronous, active-low reset
start   input   1      request a new operation; accepted only when ready=1
mode    input   1      0 = add (A+B+cin), 1 = subtract (A-B-cin); sampled with start
cin     input   1      carry/borrow in; sampled with start
adata   input   WIDTH  operand A; sampled with start
bdata   input   WIDTH  operand B; sampled with start
enable  input   1      bit-step enable during SHIFT; 0 stalls with all state held
ready   output  1      1 in IDLE only
busy    output  1      1 in SHIFT and DONE
done    output  1      one-cycle pulse when the result is valid
pout    output  WIDTH  result; holds the last completed value
cout    output  1      raw final carry (for subtract, 1 = no borrow)
ovf     output  1      two's-complement overflow of the completed operation

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, busy=0, done=0, pout=0, cout=0, ovf=0. Internal shift registers, carry and count are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - A_sr <= adata.
  - B_sr <= mode ? ~bdata : bdata.
  - c <= mode ? ~cin : cin.
  - cnt <= 0; go to SHIFT.
  - enable is ignored in this cycle.
- SHIFT, enable=1:
  - s = A_sr[0]^B_sr[0]^c; c <= majority(A_sr[0],B_sr[0],c).
  - A_sr and B_sr shift right; s is inserted at R_sr[WIDTH-1] (right shift).
  - cnt++.
  - The cycle processing bit WIDTH-1 also latches c_msb = the carry into that bit.
  - When cnt reaches WIDTH-1 and that step executes, go to DONE.
- SHIFT, enable=0: all registers hold; no timeout.
- DONE (one cycle):
  - pout <= R_sr, cout <= c, ovf <= c_msb ^ c, done=1.
  - Outputs register at the DONE->IDLE edge, so done and the new pout are both visible in the cycle following DONE entry.
  - Then go to IDLE.
- Latency with enable held high: start sampled at edge 0. Bit steps occur at edges 1..WIDTH. done=1 and pout valid in the cycle after edge WIDTH+1. ready=1 in that same cycle, so back-to-back issue is possible.
- pout, cout and ovf change only on completion. They stay stable during SHIFT and across any later IDLE period.
- start while busy=1 is ignored; no queuing.
- Arithmetic is modulo 2^WIDTH. Subtract is A + ~B + ~cin.
- Reset mid-operation aborts. Outputs return to their reset values and no done pulse is generated.
- mode, cin, adata and bdata changing after acceptance have no effect.

Optional Feature:
SERIAL_ADDSUB_ACCUM_EN
- Defined:
  - Adds input port acc (1 bit), sampled with start.
  - acc=1 loads A_sr from the current pout instead of adata, so chained sums accumulate.
  - acc=0 behaves as the base design.
- Undefined: the port is absent and A is always adata.
- Reset value of the accumulated pout is 0.

Test Plan:
1. WIDTH=8, add, adata=1, bdata=2, cin=0, enable=1 -> pout=0x03, cout=0, ovf=0; done pulses exactly 9 cycles after start is sampled.
2. Add 0xFF+0x01 -> pout=0x00, cout=1, ovf=0. Then add 0x7F+0x01 -> pout=0x80, cout=0, ovf=1.
3. Subtract (mode=1) 5-7, cin=0 -> pout=0xFE, cout=0, ovf=0. Then 0x80-0x01 -> pout=0x7F, cout=1, ovf=1.
4. Add 2+3 with enable dropped low for 4 cycles mid-SHIFT -> pout=0x05, and done arrives exactly 4 cycles later than in scenario 1. A second start pulsed while busy is ignored: exactly one done pulse, and pout=0x05.
5. Issue rst=0 at bit 4 of 0x55+0x0A -> pout=0, done never pulses, ready=1 immediately after reset. A new 1+2 then gives 0x03.
6. With SERIAL_ADDSUB_ACCUM_EN: add 10+0 (acc=0), then acc=1 with bdata=5 three times -> pout sequence 0x0A, 0x0F, 0x14, 0x19. WIDTH=16 regression: 0xFFFF+0x0001 -> pout=0x0000, cout=1, done after 17 cycles.
